change_dispenser: RTL and testbench

Sequences payout of change/refund coins from three denomination hoppers after a purchase or cancel in the vending core. Takes a Q1 fixed-point amount (value = yuan × 2), dispenses it greedily largest-coin-first with a one-coin-at-a-time request/acknowledge handshake, and skips empty hoppers. Sits between the vending FSM's charge/refund output and the hopper drivers; reports completion, progress and faults.

---
 rtl/change_dispenser.sv | 190 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Greedy coin payout sequencer over three hoppers (20/2/1 in Q1 units).
// Optional REQ watchdog enabled by defining CHANGE_ACK_TIMEOUT_EN.
module change_dispenser #(
  parameter int unsigned MAX_AMOUNT  = 40,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] amount,
  input  logic [2:0] empty,
  input  logic       clear,
  input  logic       ack,
  output logic [2:0] req,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [5:0] remaining,
  output logic [5:0] dispensed
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [5:0] MAX_AMT = 6'(MAX_AMOUNT);
  localparam logic [5:0] VAL_HI  = 6'd20;
  localparam logic [5:0] VAL_MID = 6'd2;
  localparam logic [5:0] VAL_LO  = 6'd1;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] req_q;
  logic [2:0] req_d;
  logic [5:0] rem_q;
  logic [5:0] rem_d;
  logic [5:0] disp_q;
  logic [5:0] disp_d;

  logic       fit_hi;
  logic       fit_mid;
  logic       fit_lo;
  logic [2:0] pick;
  logic [5:0] coin_val;
  logic       timeout;

  assign fit_hi  = !empty[2] && (rem_q >= VAL_HI);
  assign fit_mid = !empty[1] && (rem_q >= VAL_MID);
  assign fit_lo  = !empty[0] && (rem_q >= VAL_LO);

  // Mutually exclusive terms give largest-coin-first priority.
  always_comb begin
    pick = 3'b000;
    unique case (1'b1)
      fit_hi:                        pick = 3'b100;
      (fit_mid && !fit_hi):          pick = 3'b010;
      (fit_lo && !fit_hi && !fit_mid): pick = 3'b001;
      default:                       pick = 3'b000;
    endcase
  end

  always_comb begin
    coin_val = 6'd0;
    unique case (1'b1)
      req_q[2]: coin_val = VAL_HI;
      req_q[1]: coin_val = VAL_MID;
      req_q[0]: coin_val = VAL_LO;
      default:  coin_val = 6'd0;
    endcase
  end

`ifdef CHANGE_ACK_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  logic [7:0] timer_q;
  logic [7:0] timer_d;

  assign timeout = (timer_q == TMO_LAST);

  always_comb begin
    timer_d = timer_q;
    if (state_q == S_SELECT) begin
      timer_d = 8'd0;
    end else if (state_q == S_REQ && !ack) begin
      timer_d = timer_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= 8'd0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^8'(ACK_TIMEOUT);
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = 3'b000;
    rem_d   = rem_q;
    disp_d  = disp_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (amount == 6'd0) begin
            rem_d   = 6'd0;
            disp_d  = 6'd0;
            state_d = S_DONE;
          end else if (amount > MAX_AMT) begin
            rem_d   = amount;
            state_d = S_FAULT;
          end else begin
            rem_d   = amount;
            disp_d  = 6'd0;
            state_d = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        if (pick == 3'b000) begin
          state_d = S_FAULT;
        end else begin
          req_d   = pick;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        req_d = req_q;
        if (ack) begin
          rem_d   = rem_q - coin_val;
          disp_d  = disp_q + 6'd1;
          req_d   = 3'b000;
          state_d = S_GAP;
        end else if (timeout) begin
          req_d   = 3'b000;
          state_d = S_FAULT;
        end
      end
      S_GAP: begin
        state_d = (rem_q == 6'd0) ? S_DONE : S_SELECT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (clear) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 3'b000;
      rem_q   <= 6'd0;
      disp_q  <= 6'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rem_q   <= rem_d;
      disp_q  <= disp_d;
    end
  end

  assign req       = req_q;
  assign remaining = rem_q;
  assign dispensed = disp_q;
  assign busy      = (state_q == S_SELECT) ||
                     (state_q == S_REQ) ||
                     (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign fault     = (state_q == S_FAULT);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payout table plus timing corners.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] amount;
  logic [2:0] empty;
  logic       clear;
  logic       ack;
  logic [2:0] req;
  logic       busy;
  logic       done;
  logic       fault;
  logic [5:0] remaining;
  logic [5:0] dispensed;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  change_dispenser #(
    .MAX_AMOUNT (40),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .amount   (amount),
    .empty    (empty),
    .clear    (clear),
    .ack      (ack),
    .req      (req),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .remaining(remaining),
    .dispensed(dispensed)
  );

  typedef struct {
    int amt;
    int emp;
    int n20;
    int n2;
    int n1;
    int flt;
    int rem;
    int disp;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int idx, input vec_t v);
    int n20 = 0;
    int n2 = 0;
    int n1 = 0;
    int ord = 1;
    int fin = 0;
    logic [2:0] prev = 3'b000;
    logic [2:0] last = 3'b111;
    amount = v.amt[5:0];
    empty  = v.emp[2:0];
    start  = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 300 && fin == 0; c++) begin
      if (req != 3'b000 && prev == 3'b000) begin
        if (req == 3'b100) n20++;
        else if (req == 3'b010) n2++;
        else if (req == 3'b001) n1++;
        else ord = 0;
        if (req > last) ord = 0;
        last = req;
      end
      prev = req;
      ack  = (req != 3'b000);
      if (done || fault) fin = 1;
      else step();
    end
    ack = 1'b0;
    chk($sformatf("v%0d finished", idx), fin, 1);
    chk($sformatf("v%0d fault", idx), int'(fault), v.flt);
    chk($sformatf("v%0d remaining", idx), int'(remaining), v.rem);
    chk($sformatf("v%0d dispensed", idx), int'(dispensed), v.disp);
    chk($sformatf("v%0d n20", idx), n20, v.n20);
    chk($sformatf("v%0d n2", idx), n2, v.n2);
    chk($sformatf("v%0d n1", idx), n1, v.n1);
    chk($sformatf("v%0d order", idx), ord, 1);
    if (fault) begin
      chk($sformatf("v%0d fault req", idx), int'(req), 0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk($sformatf("v%0d cleared", idx), int'(fault), 0);
      chk($sformatf("v%0d idle busy", idx), int'(busy), 0);
    end else begin
      chk($sformatf("v%0d busy@done", idx), int'(busy), 0);
      step();
      chk($sformatf("v%0d done pulse", idx), int'(done), 0);
      chk($sformatf("v%0d rem hold", idx), int'(remaining), 0);
    end
  endtask

  initial begin
    int cnt;
    int bad;
    rst    = 1'b1;
    start  = 1'b0;
    amount = 6'd0;
    empty  = 3'b000;
    clear  = 1'b0;
    ack    = 1'b0;
    tbl[0]  = '{25, 3'b000, 1, 2, 1, 0, 0, 4};
    tbl[1]  = '{25, 3'b100, 0, 12, 1, 0, 0, 13};
    tbl[2]  = '{1, 3'b001, 0, 0, 0, 1, 1, 0};
    tbl[3]  = '{0, 3'b000, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{41, 3'b000, 0, 0, 0, 1, 41, 0};
    tbl[5]  = '{40, 3'b000, 2, 0, 0, 0, 0, 2};
    tbl[6]  = '{5, 3'b010, 0, 0, 5, 0, 0, 5};
    tbl[7]  = '{3, 3'b011, 0, 0, 0, 1, 3, 0};
    tbl[8]  = '{63, 3'b000, 0, 0, 0, 1, 63, 0};
    tbl[9]  = '{23, 3'b000, 1, 1, 1, 0, 0, 3};
    tbl[10] = '{21, 3'b001, 1, 0, 0, 1, 1, 1};
    step();
    step();
    chk("rst req", int'(req), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst fault", int'(fault), 0);
    chk("rst remaining", int'(remaining), 0);
    chk("rst dispensed", int'(dispensed), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 11; i++) run(i, tbl[i]);

    // Exact cycle timing: amount 3 -> coin 2 then coin 1.
    empty  = 3'b000;
    amount = 6'd3;
    start  = 1'b1;
    step();
    start = 1'b0;
    chk("t sel busy", int'(busy), 1);
    chk("t sel req", int'(req), 0);
    chk("t sel rem", int'(remaining), 3);
    step();
    chk("t req1", int'(req), 3'b010);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t gap req", int'(req), 0);
    chk("t gap rem", int'(remaining), 1);
    chk("t gap disp", int'(dispensed), 1);
    chk("t gap busy", int'(busy), 1);
    step();
    chk("t sel2 req", int'(req), 0);
    step();
    chk("t req2", int'(req), 3'b001);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t gap2 rem", int'(remaining), 0);
    chk("t gap2 done", int'(done), 0);
    step();
    chk("t done", int'(done), 1);
    chk("t done busy", int'(busy), 0);
    step();
    chk("t idle done", int'(done), 0);
    chk("t idle disp", int'(dispensed), 2);

    // start during REQ and ack in GAP/IDLE are ignored.
    amount = 6'd4;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    amount = 6'd10;
    start  = 1'b1;
    step();
    start = 1'b0;
    chk("i req hold", int'(req), 3'b010);
    chk("i rem", int'(remaining), 4);
    ack = 1'b1;
    step();
    chk("i gap rem", int'(remaining), 2);
    step();
    ack = 1'b0;
    chk("i sel rem", int'(remaining), 2);
    chk("i sel disp", int'(dispensed), 1);
    step();
    chk("i req2", int'(req), 3'b010);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk("i done", int'(done), 1);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("i idle rem", int'(remaining), 0);
    chk("i idle disp", int'(dispensed), 2);
    chk("i idle busy", int'(busy), 0);

    // Reset mid-payout.
    amount = 6'd4;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("r req", int'(req), 3'b010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r req0", int'(req), 0);
    chk("r busy", int'(busy), 0);
    chk("r rem", int'(remaining), 0);
    chk("r disp", int'(dispensed), 0);
    chk("r fault", int'(fault), 0);
    amount = 6'd1;
    start  = 1'b1;
    step();
    start = 1'b0;
    chk("r restart busy", int'(busy), 1);
    chk("r restart rem", int'(remaining), 1);
    step();
    chk("r restart req", int'(req), 3'b001);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    step();

    // Unacknowledged request.
    amount = 6'd4;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
`ifdef CHANGE_ACK_TIMEOUT_EN
    cnt = 0;
    for (int c = 0; c < 20 && !fault; c++) begin
      if (req == 3'b010) cnt++;
      step();
    end
    chk("wd req cycles", cnt, 8);
    chk("wd fault", int'(fault), 1);
    chk("wd req0", int'(req), 0);
    chk("wd rem", int'(remaining), 4);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("wd cleared", int'(fault), 0);
`else
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      if (req != 3'b010 || fault) bad++;
      step();
    end
    chk("hold req", bad, 0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("hold gap rem", int'(remaining), 2);
    cnt = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      ack = (req != 3'b000);
      step();
      cnt++;
    end
    ack = 1'b0;
    chk("hold done", int'(done), 1);
    chk("hold disp", int'(dispensed), 2);
    chk("hold rem", int'(remaining), 0);
`endif
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
